// File: rtl/frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frame_ctrl_pkg
// Shared types and constants for the ping-pong frame buffer controller.
//   buf_st_e      : ownership state of one DDR frame buffer
//   fsm_st_e      : writer-sequencing FSM state encoding
//   BUFx_ADDR_DEF : default byte base addresses of the two frame buffers
//   FRAME_BYTES   : size of one frame in bytes
//   oldest_ready(): picks the frame to offer to the reader
// -----------------------------------------------------------------------------
package frame_ctrl_pkg;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_st_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_START   = 3'd2,
    ST_WRITING = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_ERR     = 3'd5
  } fsm_st_e;

  localparam logic [31:0] BUF0_ADDR_DEF = 32'h2BC0_0000;
  localparam logic [31:0] BUF1_ADDR_DEF = 32'h2BE0_0000;
  localparam logic [31:0] FRAME_BYTES   = 32'd614400;

  // Returns {valid, idx}. When both buffers hold a finished frame, the one
  // that was NOT committed last is the older one.
  function automatic logic [1:0] oldest_ready(input buf_st_e st0,
                                               input buf_st_e st1,
                                               input logic    last);
    logic [1:0] res;
    if ((st0 == BUF_READY) && (st1 == BUF_READY)) begin
      res = {1'b1, ~last};
    end else if (st0 == BUF_READY) begin
      res = {1'b1, 1'b0};
    end else if (st1 == BUF_READY) begin
      res = {1'b1, 1'b1};
    end else begin
      res = {1'b0, 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_buf_tracker.sv
// -----------------------------------------------------------------------------
// frame_buf_tracker
// Owns the two buffer status registers and last_committed. Presents the oldest
// finished frame to the reader, applies reader take/release, and computes the
// writer's next target buffer (free first, otherwise reclaim the oldest ready
// frame unless the reader is taking it this very cycle).
// Ports:
//   sel_req_i      : FSM is in SELECT; a qualifying choice is applied
//   commit_i       : target buffer finished writing -> READY
//   abort_i        : target buffer write abandoned -> FREE
//   target_idx_i   : buffer the writer currently owns
//   rdy_ready_i    : reader takes the offered frame
//   release_i/_idx : reader gives a READING buffer back
//   sel_ok_o/_idx_o/_reclaim_o : selection result for this cycle
//   rdy_valid_o/_idx_o/_addr_o : registered frame offer to the reader
// -----------------------------------------------------------------------------
module frame_buf_tracker
  import frame_ctrl_pkg::*;
#(
  parameter logic [31:0] BUF0_ADDR = BUF0_ADDR_DEF,
  parameter logic [31:0] BUF1_ADDR = BUF1_ADDR_DEF
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        sel_req_i,
  input  logic        commit_i,
  input  logic        abort_i,
  input  logic        target_idx_i,
  input  logic        rdy_ready_i,
  input  logic        release_i,
  input  logic        release_idx_i,
  output logic        sel_ok_o,
  output logic        sel_idx_o,
  output logic        sel_reclaim_o,
  output logic        rdy_valid_o,
  output logic        rdy_idx_o,
  output logic [31:0] rdy_addr_o
);

  buf_st_e     st_q [2];
  buf_st_e     st_d [2];
  logic        last_q, last_d;
  logic        rdy_valid_q, rdy_valid_d;
  logic        rdy_idx_q, rdy_idx_d;
  logic [31:0] rdy_addr_q, rdy_addr_d;

  logic        hs_s;
  logic        sel_ok_s, sel_idx_s, sel_reclaim_s;
  logic        sel_go_s;

  assign hs_s     = rdy_valid_q & rdy_ready_i;
  assign sel_go_s = sel_req_i & sel_ok_s;

  // Target choice: preferred (not last committed) free, other free, then
  // reclaim of the oldest ready frame; a same-cycle reader take cancels it.
  always_comb begin
    sel_ok_s      = 1'b0;
    sel_idx_s     = 1'b0;
    sel_reclaim_s = 1'b0;
    if (st_q[~last_q] == BUF_FREE) begin
      sel_ok_s  = 1'b1;
      sel_idx_s = ~last_q;
    end else if (st_q[last_q] == BUF_FREE) begin
      sel_ok_s  = 1'b1;
      sel_idx_s = last_q;
    end else if (rdy_valid_q && !hs_s) begin
      sel_ok_s      = 1'b1;
      sel_idx_s     = rdy_idx_q;
      sel_reclaim_s = 1'b1;
    end else begin
      sel_ok_s = 1'b0;
    end
  end

  // Next buffer status. The events below always touch different buffers
  // (READY, READING, FREE/READY-not-taken, WRITING), so their order is free.
  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    if (hs_s) begin
      st_d[rdy_idx_q] = BUF_READING;
    end else begin
      st_d[rdy_idx_q] = st_d[rdy_idx_q];
    end
    if (release_i && (st_q[release_idx_i] == BUF_READING)) begin
      st_d[release_idx_i] = BUF_FREE;
    end else begin
      st_d[release_idx_i] = st_d[release_idx_i];
    end
    if (sel_go_s) begin
      st_d[sel_idx_s] = BUF_WRITING;
    end else begin
      st_d[sel_idx_s] = st_d[sel_idx_s];
    end
    if (commit_i) begin
      st_d[target_idx_i] = BUF_READY;
      last_d             = target_idx_i;
    end else if (abort_i) begin
      st_d[target_idx_i] = BUF_FREE;
    end else begin
      last_d = last_q;
    end
    {rdy_valid_d, rdy_idx_d} = oldest_ready(st_d[0], st_d[1], last_d);
    if (rdy_valid_d) begin
      rdy_addr_d = rdy_idx_d ? BUF1_ADDR : BUF0_ADDR;
    end else begin
      rdy_addr_d = 32'h0000_0000;
    end
  end

  // Status, last_committed and the registered reader offer.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st_q[0]     <= BUF_FREE;
      st_q[1]     <= BUF_FREE;
      last_q      <= 1'b1;
      rdy_valid_q <= 1'b0;
      rdy_idx_q   <= 1'b0;
      rdy_addr_q  <= 32'h0000_0000;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      last_q      <= last_d;
      rdy_valid_q <= rdy_valid_d;
      rdy_idx_q   <= rdy_idx_d;
      rdy_addr_q  <= rdy_addr_d;
    end
  end

  assign sel_ok_o      = sel_ok_s;
  assign sel_idx_o     = sel_idx_s;
  assign sel_reclaim_o = sel_reclaim_s;
  assign rdy_valid_o   = rdy_valid_q;
  assign rdy_idx_o     = rdy_idx_q;
  assign rdy_addr_o    = rdy_addr_q;

endmodule

// File: rtl/frame_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// frame_pingpong_ctrl
// Sequences a DDR frame writer across two ping-pong buffers and hands finished
// frames to a reader, oldest first. Includes a per-frame write watchdog.
// Ports:
//   clk, aresetn                 : clock, async active-low reset
//   enable                       : allow new frames to start
//   err_clr                      : clears sticky timeout_err
//   ddr_write_start(_valid/_ready): frame start handshake to the writer
//   odd_even_flag                : target buffer of the current frame
//   ddr_write_finish(_valid/_ready): frame done handshake from the writer
//   frame_rdy_valid/_idx/_addr/_ready : finished frame offer to the reader
//   frame_release, frame_release_idx  : reader returns a buffer
//   frame_count, drop_count      : committed / reclaimed frame counters
//   timeout_err                  : sticky watchdog flag
// -----------------------------------------------------------------------------
module frame_pingpong_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter logic [31:0] BUF0_ADDR      = BUF0_ADDR_DEF,
  parameter logic [31:0] BUF1_ADDR      = BUF1_ADDR_DEF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        err_clr,
  output logic        ddr_write_start,
  output logic        ddr_write_start_valid,
  input  logic        ddr_write_start_ready,
  output logic        odd_even_flag,
  input  logic        ddr_write_finish,
  input  logic        ddr_write_finish_valid,
  output logic        ddr_write_finish_ready,
  output logic        frame_rdy_valid,
  output logic        frame_rdy_idx,
  output logic [31:0] frame_rdy_addr,
  input  logic        frame_rdy_ready,
  input  logic        frame_release,
  input  logic        frame_release_idx,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic        timeout_err
);

  fsm_st_e     state_q, state_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic        oe_q, oe_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        fin_rdy_q, fin_rdy_d;
  logic        fin_prev_q;

  logic        fin_lvl_s;
  logic        fin_accept_s;
  logic        sel_ok_s, sel_idx_s, sel_reclaim_s;

  // Finish is edge-triggered so a writer holding valid high across COMMIT
  // cannot commit the following frame as well.
  assign fin_lvl_s    = ddr_write_finish_valid & ddr_write_finish;
  assign fin_accept_s = (state_q == ST_WRITING) & fin_lvl_s & ~fin_prev_q;

  frame_buf_tracker #(
    .BUF0_ADDR (BUF0_ADDR),
    .BUF1_ADDR (BUF1_ADDR)
  ) u_tracker (
    .clk           (clk),
    .aresetn       (aresetn),
    .sel_req_i     (state_q == ST_SELECT),
    .commit_i      (state_q == ST_COMMIT),
    .abort_i       (state_q == ST_ERR),
    .target_idx_i  (oe_q),
    .rdy_ready_i   (frame_rdy_ready),
    .release_i     (frame_release),
    .release_idx_i (frame_release_idx),
    .sel_ok_o      (sel_ok_s),
    .sel_idx_o     (sel_idx_s),
    .sel_reclaim_o (sel_reclaim_s),
    .rdy_valid_o   (frame_rdy_valid),
    .rdy_idx_o     (frame_rdy_idx),
    .rdy_addr_o    (frame_rdy_addr)
  );

  // Next-state, watchdog, counters and registered writer-side outputs.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    oe_d    = oe_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SELECT;
        else        state_d = ST_IDLE;
      end
      ST_SELECT: begin
        if (sel_ok_s) begin
          state_d = ST_START;
          oe_d    = sel_idx_s;
          if (sel_reclaim_s) dcnt_d = dcnt_q + 16'd1;
          else               dcnt_d = dcnt_q;
        end else begin
          state_d = ST_SELECT;
        end
      end
      ST_START: begin
        if (ddr_write_start_ready) begin
          state_d = ST_WRITING;
          wd_d    = 32'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_WRITING: begin
        if (fin_accept_s) begin
          state_d = ST_COMMIT;
        end else if (wd_q == (TIMEOUT_CYCLES - 32'd1)) begin
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      ST_COMMIT: begin
        fcnt_d = fcnt_q + 16'd1;
        if (enable) state_d = ST_SELECT;
        else        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // err_clr wins over a same-cycle set.
    if (err_clr)                err_d = 1'b0;
    else if (state_q == ST_ERR) err_d = 1'b1;
    else                        err_d = err_q;

    // Start stays asserted through WRITING; the writer samples it per burst.
    start_d   = (state_d == ST_START) || (state_d == ST_WRITING);
    fin_rdy_d = (state_d == ST_WRITING);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      wd_q       <= 32'd0;
      fcnt_q     <= 16'd0;
      dcnt_q     <= 16'd0;
      oe_q       <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      fin_rdy_q  <= 1'b0;
      fin_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      fcnt_q     <= fcnt_d;
      dcnt_q     <= dcnt_d;
      oe_q       <= oe_d;
      err_q      <= err_d;
      start_q    <= start_d;
      fin_rdy_q  <= fin_rdy_d;
      fin_prev_q <= fin_lvl_s;
    end
  end

  assign ddr_write_start        = start_q;
  assign ddr_write_start_valid  = start_q;
  assign ddr_write_finish_ready = fin_rdy_q;
  assign odd_even_flag          = oe_q;
  assign frame_count            = fcnt_q;
  assign drop_count             = dcnt_q;
  assign timeout_err            = err_q;

endmodule

// File: tb/tb_frame_pingpong_ctrl.sv
module tb_frame_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable, err_clr;
  logic        ddr_write_start, ddr_write_start_valid, ddr_write_start_ready;
  logic        odd_even_flag;
  logic        ddr_write_finish, ddr_write_finish_valid, ddr_write_finish_ready;
  logic        frame_rdy_valid, frame_rdy_idx, frame_rdy_ready;
  logic [31:0] frame_rdy_addr;
  logic        frame_release, frame_release_idx;
  logic [15:0] frame_count, drop_count;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_pingpong_ctrl #(
    .BUF0_ADDR      (32'h2BC0_0000),
    .BUF1_ADDR      (32'h2BE0_0000),
    .TIMEOUT_CYCLES (32'd1000)
  ) dut (
    .clk                    (clk),
    .aresetn                (aresetn),
    .enable                 (enable),
    .err_clr                (err_clr),
    .ddr_write_start        (ddr_write_start),
    .ddr_write_start_valid  (ddr_write_start_valid),
    .ddr_write_start_ready  (ddr_write_start_ready),
    .odd_even_flag          (odd_even_flag),
    .ddr_write_finish       (ddr_write_finish),
    .ddr_write_finish_valid (ddr_write_finish_valid),
    .ddr_write_finish_ready (ddr_write_finish_ready),
    .frame_rdy_valid        (frame_rdy_valid),
    .frame_rdy_idx          (frame_rdy_idx),
    .frame_rdy_addr         (frame_rdy_addr),
    .frame_rdy_ready        (frame_rdy_ready),
    .frame_release          (frame_release),
    .frame_release_idx      (frame_release_idx),
    .frame_count            (frame_count),
    .drop_count             (drop_count),
    .timeout_err            (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ddr_write_start_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic ack_start(input int dly);
    tick(dly);
    ddr_write_start_ready = 1'b1;
    tick(1);
    ddr_write_start_ready = 1'b0;
  endtask

  task automatic finish_pulse();
    ddr_write_finish = 1'b1;
    ddr_write_finish_valid = 1'b1;
    tick(1);
    ddr_write_finish = 1'b0;
    ddr_write_finish_valid = 1'b0;
  endtask

  task automatic take(input int n);
    frame_rdy_ready = 1'b1;
    tick(n);
    frame_rdy_ready = 1'b0;
  endtask

  task automatic release_buf(input logic idx);
    frame_release = 1'b1;
    frame_release_idx = idx;
    tick(1);
    frame_release = 1'b0;
    frame_release_idx = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; err_clr = 1'b0;
    ddr_write_start_ready = 1'b0; ddr_write_finish = 1'b0; ddr_write_finish_valid = 1'b0;
    frame_rdy_ready = 1'b0; frame_release = 1'b0; frame_release_idx = 1'b0;
    tick(3);
    chk("rst_start_valid", ddr_write_start_valid, 32'd0);
    chk("rst_start", ddr_write_start, 32'd0);
    chk("rst_flag", odd_even_flag, 32'd0);
    chk("rst_fin_ready", ddr_write_finish_ready, 32'd0);
    chk("rst_rdy_valid", frame_rdy_valid, 32'd0);
    chk("rst_rdy_addr", frame_rdy_addr, 32'd0);
    chk("rst_fcnt", frame_count, 32'd0);
    chk("rst_dcnt", drop_count, 32'd0);
    chk("rst_terr", timeout_err, 32'd0);
    aresetn = 1'b1;
    enable = 1'b1;

    // 1: first frame lands in buffer 0
    wait_start("t1_start");
    chk("t1_flag", odd_even_flag, 32'd0);
    ack_start(3);
    chk("t1_fin_ready", ddr_write_finish_ready, 32'd1);
    chk("t1_start_held", ddr_write_start, 32'd1);
    tick(100);
    finish_pulse();
    tick(1);
    chk("t1_rdy_valid", frame_rdy_valid, 32'd1);
    chk("t1_rdy_idx", frame_rdy_idx, 32'd0);
    chk("t1_rdy_addr", frame_rdy_addr, 32'h2BC0_0000);
    chk("t1_fcnt", frame_count, 32'd1);

    // 2: idle reader, frames 0,1,0 with reclaim of buffer 0
    wait_start("t2_f2_start");
    chk("t2_f2_flag", odd_even_flag, 32'd1);
    ack_start(3);
    tick(10);
    finish_pulse();
    tick(1);
    chk("t2_fcnt2", frame_count, 32'd2);
    chk("t2_oldest_idx", frame_rdy_idx, 32'd0);
    wait_start("t2_f3_start");
    chk("t2_f3_flag", odd_even_flag, 32'd0);
    chk("t2_dcnt", drop_count, 32'd1);
    chk("t2_offer_valid", frame_rdy_valid, 32'd1);
    chk("t2_offer_idx", frame_rdy_idx, 32'd1);
    chk("t2_offer_addr", frame_rdy_addr, 32'h2BE0_0000);
    ack_start(3);
    enable = 1'b0;
    tick(5);
    take(1);
    chk("t2_taken_valid", frame_rdy_valid, 32'd0);
    tick(5);
    finish_pulse();
    tick(1);
    chk("t2_fcnt3", frame_count, 32'd3);
    chk("t2_offer0_valid", frame_rdy_valid, 32'd1);
    chk("t2_offer0_idx", frame_rdy_idx, 32'd0);
    tick(5);
    chk("t2_idle_no_start", ddr_write_start_valid, 32'd0);
    release_buf(1'b0);   // buffer 0 is READY, not READING: ignored
    chk("t2_bad_release_valid", frame_rdy_valid, 32'd1);
    chk("t2_bad_release_idx", frame_rdy_idx, 32'd0);
    release_buf(1'b1);

    // 3: reader holds buffers; SELECT waits for a release
    take(1);
    chk("t3_taken0", frame_rdy_valid, 32'd0);
    enable = 1'b1;
    wait_start("t3_f4_start");
    chk("t3_f4_flag", odd_even_flag, 32'd1);
    ack_start(2);
    enable = 1'b0;
    tick(5);
    finish_pulse();
    tick(1);
    chk("t3_fcnt4", frame_count, 32'd4);
    chk("t3_offer1", frame_rdy_idx, 32'd1);
    take(1);
    enable = 1'b1;
    tick(10);
    chk("t3_stall_start", ddr_write_start_valid, 32'd0);
    chk("t3_stall_dcnt", drop_count, 32'd1);
    release_buf(1'b0);
    wait_start("t3_after_release");
    chk("t3_flag0", odd_even_flag, 32'd0);

    // 4: finish valid held across COMMIT commits exactly once per edge
    ack_start(2);
    release_buf(1'b1);
    ddr_write_finish = 1'b1;
    ddr_write_finish_valid = 1'b1;
    tick(2);
    chk("t4_fcnt5", frame_count, 32'd5);
    wait_start("t4_next_start");
    chk("t4_next_flag", odd_even_flag, 32'd1);
    ack_start(1);
    tick(10);
    chk("t4_no_double", frame_count, 32'd5);
    chk("t4_still_writing", ddr_write_finish_ready, 32'd1);
    enable = 1'b0;
    ddr_write_finish_valid = 1'b0;
    tick(1);
    ddr_write_finish_valid = 1'b1;
    tick(2);
    chk("t4_fcnt6", frame_count, 32'd6);
    ddr_write_finish = 1'b0;
    ddr_write_finish_valid = 1'b0;
    chk("t4_offer_idx", frame_rdy_idx, 32'd0);

    // 5: watchdog
    take(2);
    chk("t5_all_taken", frame_rdy_valid, 32'd0);
    release_buf(1'b0);
    release_buf(1'b1);
    enable = 1'b1;
    wait_start("t5_start");
    chk("t5_flag", odd_even_flag, 32'd0);
    ack_start(1);
    tick(999);
    chk("t5_pre_timeout", ddr_write_start_valid, 32'd1);
    chk("t5_pre_terr", timeout_err, 32'd0);
    tick(1);
    chk("t5_err_start_low", ddr_write_start_valid, 32'd0);
    tick(1);
    chk("t5_terr_set", timeout_err, 32'd1);
    chk("t5_fcnt", frame_count, 32'd6);
    tick(3);
    chk("t5_terr_sticky", timeout_err, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t5_terr_clr", timeout_err, 32'd0);
    wait_start("t5_restart");
    chk("t5_restart_flag", odd_even_flag, 32'd0);
    ack_start(1);
    enable = 1'b0;
    tick(5);
    finish_pulse();
    tick(1);
    chk("t5_fcnt7", frame_count, 32'd7);
    chk("t5_offer_idx", frame_rdy_idx, 32'd0);

    // 6: reader take beats a same-cycle reclaim
    enable = 1'b1;
    wait_start("t6_start");
    chk("t6_flag", odd_even_flag, 32'd1);
    ack_start(1);
    tick(5);
    finish_pulse();
    tick(1);
    chk("t6_oldest", frame_rdy_idx, 32'd0);
    frame_rdy_ready = 1'b1;
    tick(1);
    chk("t6_dcnt_kept", drop_count, 32'd1);
    chk("t6_no_start", ddr_write_start_valid, 32'd0);
    tick(1);
    frame_rdy_ready = 1'b0;
    chk("t6_both_taken", frame_rdy_valid, 32'd0);
    tick(10);
    chk("t6_stall_start", ddr_write_start_valid, 32'd0);
    chk("t6_stall_dcnt", drop_count, 32'd1);
    release_buf(1'b0);
    wait_start("t6_after_release");
    chk("t6_flag0", odd_even_flag, 32'd0);
    ack_start(1);
    tick(5);
    chk("t6_writing", ddr_write_start_valid, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst2_start_valid", ddr_write_start_valid, 32'd0);
    chk("rst2_fin_ready", ddr_write_finish_ready, 32'd0);
    chk("rst2_flag", odd_even_flag, 32'd0);
    chk("rst2_fcnt", frame_count, 32'd0);
    chk("rst2_dcnt", drop_count, 32'd0);
    chk("rst2_rdy_valid", frame_rdy_valid, 32'd0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
